mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage of the CPU; sits between the EX/MEM boundary and the control unit.
- Performs word load/store over the shared bus with a request/grant/address-strobe/ready handshake.
- Detects misaligned accesses and registers the MEM/WB outputs (MemPC, MemEn, MemOut, MemExpCode, ...) that the control unit consumes.
- Drives MemBusy, which folds into the global pipeline stall.

Parameters:
- WORD_DATA_W, 32, data word width
- WORD_ADDR_W, 30, word address width (byte address minus 2 offset bits)
- REG_ADDR_W, 5, register address width
- EXP_W, 3, exception code width; 0 = no exception, 4 = misaligned access
- CTRL_OP_W, 2, control op width; 0 = NOP

Ports:
- clk  in  1  single clock
- reset_  in  1  asynchronous, active-low reset
- ExEn  in  1  EX-stage instruction valid
- ExPC  in  WORD_ADDR_W  EX-stage PC
- ExBrFlag  in  1  EX-stage instruction is in a branch delay slot
- ExMemOp  in  2  0 = none, 1 = LDW, 2 = STW, 3 = reserved (treated as none)
- ExMemWrData  in  WORD_DATA_W  store data
- ExOut  in  WORD_DATA_W  ALU result / byte address
- ExCtrlOp  in  CTRL_OP_W  control op, passed through
- ExDstAddr  in  REG_ADDR_W  destination register
- ExGPRWE_  in  1  GPR write enable, active low
- ExExpCode  in  EXP_W  upstream exception code
- Stall  in  1  global stall (MemStall)
- Flush  in  1  MemFlush
- BusReq_  out  1  bus request, active low
- BusGrnt_  in  1  bus grant, active low
- BusAs_  out  1  address strobe, active low
- BusRw  out  1  1 = read, 0 = write
- BusAddr  out  WORD_ADDR_W  word address
- BusWrData  out  WORD_DATA_W  write data
- BusRdData  in  WORD_DATA_W  read data
- BusRdy_  in  1  transfer ready, active low
- MemBusy  out  1  stage busy (stall request)
- MemEn, MemPC, MemBrFlag, MemCtrlOp, MemDstAddr, MemGPRWE_, MemExpCode, MemOut  out  (widths as Ex counterparts)  MEM/WB register

Behaviour:
- Reset (async, reset_ = 0) forces the FSM to IDLE and every output to its bubble/idle value:
  - MemEn = 0, MemPC = 0, MemBrFlag = 0, MemCtrlOp = 0, MemDstAddr = 0, MemGPRWE_ = 1, MemExpCode = 0, MemOut = 0.
  - BusReq_ = 1, BusAs_ = 1, BusRw = 1, BusAddr = 0, BusWrData = 0, MemBusy = 0.
  - Reset mid-transfer abandons the transfer immediately.
- Misalign = ExOut[1:0] != 0 with ExMemOp in {LDW, STW}.
- Access = ExEn & (ExMemOp in {LDW, STW}) & ExExpCode == 0 & !Misalign & !Flush.
- FSM has four states: IDLE, REQ, ACCESS, DONE.
  - IDLE: when Access, drive BusReq_ = 0 combinationally, set MemBusy = 1, go to REQ; otherwise MemBusy = 0.
  - REQ: BusReq_ = 0, MemBusy = 1. When BusGrnt_ = 0, go to ACCESS. If Flush, release the request and go to IDLE.
  - ACCESS: BusReq_ = 0 and BusAs_ = 0; BusAddr = ExOut[31:2]; BusRw = (op == LDW); BusWrData = ExMemWrData.
    - While BusRdy_ = 1, MemBusy = 1.
    - On BusRdy_ = 0, MemBusy = 0 and BusRdData is latched into RdBuf.
    - Next state: DONE if Stall = 1, otherwise IDLE.
    - Flush does not abort ACCESS; the result is discarded via the register rule below.
  - DONE: bus idle, MemBusy = 0, RdBuf held. When Stall = 0, go to IDLE. The access is never re-issued for the same instruction.
- Load data select: BusRdData in the ACCESS completion cycle; RdBuf in DONE.
- MEM/WB register update:
  - Stall = 1: hold.
  - Stall = 0 and Flush = 1: load bubble.
  - Stall = 0 and Flush = 0: capture.
- Capture rules:
  - MemEn, MemPC, MemBrFlag, MemCtrlOp and MemDstAddr are copied from their Ex counterparts.
  - MemExpCode = ExExpCode if nonzero; else 4 if Misalign; else 0.
  - MemGPRWE_ = 1 if MemExpCode is nonzero or op is STW; else ExGPRWE_.
  - MemOut = load data for LDW with no exception; else ExOut.
  - ExEn = 0 captures a bubble.
- Precedence of an upstream exception over Misalign: no bus request is made.
- Latency: a non-memory op passes through in 1 cycle. A load/store costs at least 3 cycles (IDLE→REQ→ACCESS); each cycle BusGrnt_ or BusRdy_ is late adds one stall cycle.

Test Plan:
- ALU pass-through: ExEn = 1, ExMemOp = 0, ExOut = 0x12345678, ExDstAddr = 3 → next cycle MemOut = 0x12345678, MemEn = 1, MemDstAddr = 3; no BusReq_.
- Load: LDW, ExOut = 0x00000100; grant after 2 cycles; BusRdy_ = 0 with BusRdData = 0xCAFEBABE → BusAddr = 0x40, BusRw = 1; MemBusy high until the ready cycle; MemOut = 0xCAFEBABE.
- Store: STW, ExOut = 0x00000204, data 0xDEADBEEF → BusRw = 0, BusAddr = 0x81, BusWrData = 0xDEADBEEF; MemGPRWE_ = 1.
- Misaligned: LDW at 0x00000102 → no bus activity, MemExpCode = 4, MemGPRWE_ = 1. Also ExExpCode = 2 with misaligned address → MemExpCode = 2.
- Stall after ready: Stall held 3 cycles past BusRdy_ → FSM in DONE; exactly one BusAs_ assertion; MemOut = the latched data when Stall drops.
- Flush: Flush in REQ → BusReq_ released next cycle, MemEn = 0. Reset asserted during ACCESS → all outputs at reset values immediately.

Source files
------------

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- MEM pipeline stage
//
// Performs word loads and stores over the shared bus using a
// request / grant / address-strobe / ready handshake. It also flags
// misaligned accesses and holds the MEM/WB pipeline register that the
// control unit reads.
//
// Ports
//   clk, reset_          clock; asynchronous active-low reset
//   Ex*                  EX/MEM boundary inputs (instruction valid, PC,
//                        memory op, store data, ALU result / byte address,
//                        control op, destination register, GPR write
//                        enable, upstream exception code)
//   Stall, Flush         global pipeline stall and MEM flush
//   Bus*                 shared bus master port (all strobes active low)
//   MemBusy              stall request while a bus access is in flight
//   Mem*                 MEM/WB register outputs
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int WORD_DATA_W = 32,
    parameter int WORD_ADDR_W = 30,
    parameter int REG_ADDR_W  = 5,
    parameter int EXP_W       = 3,
    parameter int CTRL_OP_W   = 2
) (
    input  logic                   clk,
    input  logic                   reset_,
    // EX/MEM boundary
    input  logic                   ExEn,
    input  logic [WORD_ADDR_W-1:0] ExPC,
    input  logic                   ExBrFlag,
    input  logic [1:0]             ExMemOp,
    input  logic [WORD_DATA_W-1:0] ExMemWrData,
    input  logic [WORD_DATA_W-1:0] ExOut,
    input  logic [CTRL_OP_W-1:0]   ExCtrlOp,
    input  logic [REG_ADDR_W-1:0]  ExDstAddr,
    input  logic                   ExGPRWE_,
    input  logic [EXP_W-1:0]       ExExpCode,
    // pipeline control
    input  logic                   Stall,
    input  logic                   Flush,
    // bus master port
    output logic                   BusReq_,
    input  logic                   BusGrnt_,
    output logic                   BusAs_,
    output logic                   BusRw,
    output logic [WORD_ADDR_W-1:0] BusAddr,
    output logic [WORD_DATA_W-1:0] BusWrData,
    input  logic [WORD_DATA_W-1:0] BusRdData,
    input  logic                   BusRdy_,
    // stall request
    output logic                   MemBusy,
    // MEM/WB register
    output logic                   MemEn,
    output logic [WORD_ADDR_W-1:0] MemPC,
    output logic                   MemBrFlag,
    output logic [CTRL_OP_W-1:0]   MemCtrlOp,
    output logic [REG_ADDR_W-1:0]  MemDstAddr,
    output logic                   MemGPRWE_,
    output logic [EXP_W-1:0]       MemExpCode,
    output logic [WORD_DATA_W-1:0] MemOut
);

    localparam logic [1:0]       OP_LDW       = 2'd1;
    localparam logic [1:0]       OP_STW       = 2'd2;
    localparam logic [EXP_W-1:0] EXP_NONE     = '0;
    localparam logic [EXP_W-1:0] EXP_MISALIGN = EXP_W'(4);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t                 state_reg;
    logic [WORD_DATA_W-1:0] rd_buf_reg;

    // ------------------------------------------------------------------
    // Access qualification
    // ------------------------------------------------------------------
    logic is_mem_op;
    logic is_load;
    logic is_store;
    logic misalign;
    logic access;

    assign is_load   = (ExMemOp == OP_LDW);
    assign is_store  = (ExMemOp == OP_STW);
    assign is_mem_op = is_load | is_store;
    assign misalign  = is_mem_op & (ExOut[1:0] != 2'b00);
    // An upstream exception suppresses the bus request even when the
    // address is also misaligned.
    assign access    = ExEn & is_mem_op & (ExExpCode == EXP_NONE) & ~misalign & ~Flush;

    // ------------------------------------------------------------------
    // Bus FSM and read buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_reg  <= ST_IDLE;
            rd_buf_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (access) state_reg <= ST_REQ;
                end
                ST_REQ: begin
                    // Flush wins over a grant arriving in the same cycle.
                    if (Flush)          state_reg <= ST_IDLE;
                    else if (!BusGrnt_) state_reg <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // Flush cannot abort a started transfer; the result is
                    // dropped by the MEM/WB bubble instead.
                    if (!BusRdy_) begin
                        rd_buf_reg <= BusRdData;
                        state_reg  <= Stall ? ST_DONE : ST_IDLE;
                    end
                end
                ST_DONE: begin
                    // Wait here with the data parked so the same
                    // instruction is never issued to the bus twice.
                    if (!Stall) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus outputs and busy. The request is raised combinationally in IDLE
    // so grant can arrive one cycle earlier. Everything is gated by reset_
    // so an asserted reset forces idle values at once, even while the EX
    // inputs still describe a memory access.
    // ------------------------------------------------------------------
    logic req_active;
    logic as_active;
    logic busy_active;

    assign req_active  = ((state_reg == ST_IDLE) & access) |
                         (state_reg == ST_REQ) |
                         (state_reg == ST_ACCESS);
    assign as_active   = reset_ & (state_reg == ST_ACCESS);
    assign busy_active = ((state_reg == ST_IDLE) & access) |
                         (state_reg == ST_REQ) |
                         ((state_reg == ST_ACCESS) & BusRdy_);

    assign BusReq_   = ~(reset_ & req_active);
    assign BusAs_    = ~as_active;
    assign BusRw     = as_active ? is_load : 1'b1;
    assign BusAddr   = as_active ? ExOut[WORD_ADDR_W+1:2] : '0;
    assign BusWrData = as_active ? ExMemWrData : '0;
    assign MemBusy   = reset_ & busy_active;

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    logic [WORD_DATA_W-1:0] load_data;
    logic [EXP_W-1:0]       exp_code_next;
    logic                   gprwe_n_next;
    logic [WORD_DATA_W-1:0] out_next;

    // Live bus data on the completion cycle, parked copy once in DONE.
    assign load_data     = (state_reg == ST_DONE) ? rd_buf_reg : BusRdData;
    assign exp_code_next = (ExExpCode != EXP_NONE) ? ExExpCode :
                           misalign                ? EXP_MISALIGN : EXP_NONE;
    assign gprwe_n_next  = ((exp_code_next != EXP_NONE) | is_store) ? 1'b1 : ExGPRWE_;
    assign out_next      = (is_load & (exp_code_next == EXP_NONE)) ? load_data : ExOut;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            MemEn      <= 1'b0;
            MemPC      <= '0;
            MemBrFlag  <= 1'b0;
            MemCtrlOp  <= '0;
            MemDstAddr <= '0;
            MemGPRWE_  <= 1'b1;
            MemExpCode <= '0;
            MemOut     <= '0;
        end else if (!Stall) begin
            if (Flush || !ExEn) begin
                MemEn      <= 1'b0;
                MemPC      <= '0;
                MemBrFlag  <= 1'b0;
                MemCtrlOp  <= '0;
                MemDstAddr <= '0;
                MemGPRWE_  <= 1'b1;
                MemExpCode <= '0;
                MemOut     <= '0;
            end else begin
                MemEn      <= ExEn;
                MemPC      <= ExPC;
                MemBrFlag  <= ExBrFlag;
                MemCtrlOp  <= ExCtrlOp;
                MemDstAddr <= ExDstAddr;
                MemGPRWE_  <= gprwe_n_next;
                MemExpCode <= exp_code_next;
                MemOut     <= out_next;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage
//
// Stalls are looped back the way the pipeline does it
// (Stall = MemBusy | extra stall). A bus slave with per-transaction grant
// and ready delays answers requests. Expected MEM/WB contents, bus fields
// and latency come from the instruction-level rules.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset_;
    logic        ExEn;
    logic [29:0] ExPC;
    logic        ExBrFlag;
    logic [1:0]  ExMemOp;
    logic [31:0] ExMemWrData;
    logic [31:0] ExOut;
    logic [1:0]  ExCtrlOp;
    logic [4:0]  ExDstAddr;
    logic        ExGPRWE_;
    logic [2:0]  ExExpCode;
    logic        Stall;
    logic        Flush;
    logic        BusReq_;
    logic        BusGrnt_;
    logic        BusAs_;
    logic        BusRw;
    logic [29:0] BusAddr;
    logic [31:0] BusWrData;
    logic [31:0] BusRdData;
    logic        BusRdy_;
    logic        MemBusy;
    logic        MemEn;
    logic [29:0] MemPC;
    logic        MemBrFlag;
    logic [1:0]  MemCtrlOp;
    logic [4:0]  MemDstAddr;
    logic        MemGPRWE_;
    logic [2:0]  MemExpCode;
    logic [31:0] MemOut;

    logic        ext_stall;
    int          checks = 0;
    int          errors = 0;
    int          txn_no = 0;

    assign Stall = MemBusy | ext_stall;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk         (clk),
        .reset_      (reset_),
        .ExEn        (ExEn),
        .ExPC        (ExPC),
        .ExBrFlag    (ExBrFlag),
        .ExMemOp     (ExMemOp),
        .ExMemWrData (ExMemWrData),
        .ExOut       (ExOut),
        .ExCtrlOp    (ExCtrlOp),
        .ExDstAddr   (ExDstAddr),
        .ExGPRWE_    (ExGPRWE_),
        .ExExpCode   (ExExpCode),
        .Stall       (Stall),
        .Flush       (Flush),
        .BusReq_     (BusReq_),
        .BusGrnt_    (BusGrnt_),
        .BusAs_      (BusAs_),
        .BusRw       (BusRw),
        .BusAddr     (BusAddr),
        .BusWrData   (BusWrData),
        .BusRdData   (BusRdData),
        .BusRdy_     (BusRdy_),
        .MemBusy     (MemBusy),
        .MemEn       (MemEn),
        .MemPC       (MemPC),
        .MemBrFlag   (MemBrFlag),
        .MemCtrlOp   (MemCtrlOp),
        .MemDstAddr  (MemDstAddr),
        .MemGPRWE_   (MemGPRWE_),
        .MemExpCode  (MemExpCode),
        .MemOut      (MemOut)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Checks every output against its reset / idle value.
    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_MemEn"},      32'(MemEn),      32'd0);
        check({pfx, "_MemPC"},      32'(MemPC),      32'd0);
        check({pfx, "_MemBrFlag"},  32'(MemBrFlag),  32'd0);
        check({pfx, "_MemCtrlOp"},  32'(MemCtrlOp),  32'd0);
        check({pfx, "_MemDstAddr"}, 32'(MemDstAddr), 32'd0);
        check({pfx, "_MemGPRWE_"},  32'(MemGPRWE_),  32'd1);
        check({pfx, "_MemExpCode"}, 32'(MemExpCode), 32'd0);
        check({pfx, "_MemOut"},     MemOut,          32'd0);
        check({pfx, "_BusReq_"},    32'(BusReq_),    32'd1);
        check({pfx, "_BusAs_"},     32'(BusAs_),     32'd1);
        check({pfx, "_BusRw"},      32'(BusRw),      32'd1);
        check({pfx, "_BusAddr"},    32'(BusAddr),    32'd0);
        check({pfx, "_BusWrData"},  BusWrData,       32'd0);
        check({pfx, "_MemBusy"},    32'(MemBusy),    32'd0);
    endtask

    // Issues one instruction at the current negedge, plays the bus slave,
    // and checks the MEM/WB result one negedge after it was captured.
    task automatic run_instr(input logic en, input logic [1:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] dst,
                             input logic gprwe_n, input logic [2:0] expc,
                             input int gd, input int rd, input int stall_after,
                             input logic [31:0] rdata);
        logic [29:0] pc;
        logic        brf;
        logic [1:0]  cop;
        logic        memop, mis, acc;
        logic [2:0]  e_code;
        logic        e_gprwe;
        logic [31:0] e_out;
        int          e_lat, cyc, req_cycles, as_cycles, as_rises, stall_left;
        logic        req_seen, as_prev, rdy_given, done;

        pc  = 30'($urandom);
        brf = 1'($urandom);
        cop = 2'($urandom);

        ExEn = en; ExPC = pc; ExBrFlag = brf; ExMemOp = op; ExMemWrData = wdata;
        ExOut = addr; ExCtrlOp = cop; ExDstAddr = dst; ExGPRWE_ = gprwe_n; ExExpCode = expc;

        // Instruction-level expectations
        memop  = (op == 2'd1) || (op == 2'd2);
        mis    = memop && (addr % 4 != 0);
        acc    = en && memop && (expc == 0) && !mis;
        e_code = !en ? 3'd0 : (expc != 0) ? expc : mis ? 3'd4 : 3'd0;
        e_gprwe = !en ? 1'b1 : ((e_code != 0) || op == 2'd2) ? 1'b1 : gprwe_n;
        e_out  = !en ? 32'd0 : (op == 2'd1 && e_code == 0) ? rdata : addr;
        e_lat  = acc ? (3 + gd + rd + stall_after) : (1 + stall_after);

        cyc = 0; req_cycles = 0; as_cycles = 0; as_rises = 0; stall_left = stall_after;
        req_seen = 0; as_prev = 0; rdy_given = 0; done = 0;

        while (!done && cyc < 60) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            BusGrnt_ = 1'b1; BusRdy_ = 1'b1; ext_stall = 1'b0;
            #1;
            if (!BusReq_) begin
                req_seen = 1;
                req_cycles++;
            end
            if (!BusAs_) begin
                as_cycles++;
                if (!as_prev) begin
                    as_rises++;
                    if (as_rises == 1) begin
                        check("bus_addr",  32'(BusAddr), 32'(addr / 4));
                        check("bus_rw",    32'(BusRw),   32'(op == 2'd1));
                        check("bus_wdata", BusWrData,    wdata);
                    end
                end
            end
            as_prev   = !BusAs_;
            BusGrnt_  = !(!BusReq_ && req_cycles > 1 + gd);
            BusRdy_   = !(!BusAs_ && as_cycles > rd);
            // Outside the ready cycle the read bus carries junk.
            BusRdData = !BusRdy_ ? rdata : $urandom;
            if (!BusRdy_) rdy_given = 1;
            if ((!acc || rdy_given) && stall_left > 0) begin
                ext_stall = 1'b1;
                stall_left--;
            end
            #1;
            if (!Stall) done = 1;
        end

        if (!done) check("timeout", 32'(cyc), 32'(e_lat));
        @(negedge clk);
        BusGrnt_ = 1'b1; BusRdy_ = 1'b1; ext_stall = 1'b0;

        check("latency",    32'(cyc),        32'(e_lat));
        check("req_seen",   32'(req_seen),   32'(acc));
        check("as_count",   32'(as_rises),   32'(acc));
        check("MemEn",      32'(MemEn),      32'(en));
        check("MemPC",      32'(MemPC),      en ? 32'(pc) : 32'd0);
        check("MemBrFlag",  32'(MemBrFlag),  en ? 32'(brf) : 32'd0);
        check("MemCtrlOp",  32'(MemCtrlOp),  en ? 32'(cop) : 32'd0);
        check("MemDstAddr", 32'(MemDstAddr), en ? 32'(dst) : 32'd0);
        check("MemGPRWE_",  32'(MemGPRWE_),  32'(e_gprwe));
        check("MemExpCode", 32'(MemExpCode), 32'(e_code));
        check("MemOut",     MemOut,          e_out);
        txn_no++;
        $display("txn %0d en=%0d op=%0d addr=%h exp=%0d gd=%0d rd=%0d st=%0d lat=%0d out=%h",
                 txn_no, en, op, addr, expc, gd, rd, stall_after, cyc, MemOut);
    endtask

    initial begin
        reset_ = 1'b0; Flush = 1'b0; ext_stall = 1'b0;
        ExEn = 1'b0; ExPC = '0; ExBrFlag = 1'b0; ExMemOp = 2'd0; ExMemWrData = '0;
        ExOut = '0; ExCtrlOp = '0; ExDstAddr = '0; ExGPRWE_ = 1'b1; ExExpCode = '0;
        BusGrnt_ = 1'b1; BusRdy_ = 1'b1; BusRdData = '0;

        repeat (2) @(negedge clk);
        check_idle_outputs("rst");
        reset_ = 1'b1;
        @(negedge clk);

        // Directed cases
        run_instr(1, 2'd0, 32'h1234_5678, 32'h0,         5'd3, 0, 3'd0, 0, 0, 0, 32'h0);
        run_instr(1, 2'd1, 32'h0000_0100, 32'h0,         5'd7, 0, 3'd0, 2, 0, 0, 32'hCAFE_BABE);
        run_instr(1, 2'd2, 32'h0000_0204, 32'hDEAD_BEEF, 5'd9, 0, 3'd0, 0, 1, 0, 32'h0);
        run_instr(1, 2'd1, 32'h0000_0102, 32'h0,         5'd4, 0, 3'd0, 0, 0, 0, 32'h5555_AAAA);
        run_instr(1, 2'd1, 32'h0000_0102, 32'h0,         5'd4, 0, 3'd2, 0, 0, 0, 32'h5555_AAAA);
        run_instr(1, 2'd1, 32'h0000_0400, 32'h0,         5'd6, 0, 3'd0, 1, 1, 3, 32'h0BAD_F00D);
        run_instr(1, 2'd3, 32'h0000_0003, 32'h0,         5'd2, 0, 3'd0, 0, 0, 0, 32'h0);
        run_instr(0, 2'd1, 32'h0000_0100, 32'h0,         5'd2, 0, 3'd0, 0, 0, 1, 32'h0);

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            logic [2:0]  e;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            e = ($urandom_range(0, 6) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            run_instr($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), a, $urandom,
                      5'($urandom), 1'($urandom), e, $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
        end

        // Flush while waiting for grant
        run_instr(1, 2'd0, 32'h0000_0011, 32'h0, 5'd1, 0, 3'd0, 0, 0, 0, 32'h0);
        ExEn = 1'b1; ExMemOp = 2'd1; ExOut = 32'h0000_0100; ExExpCode = '0;
        BusGrnt_ = 1'b1;
        @(negedge clk);
        Flush = 1'b1;
        #1;
        check("flush_req_held", 32'(BusReq_), 32'd0);
        check("flush_hold_en",  32'(MemEn),   32'd1);
        @(negedge clk);
        #1;
        check("flush_req_rel",  32'(BusReq_), 32'd1);
        check("flush_busy",     32'(MemBusy), 32'd0);
        @(negedge clk);
        check("flush_MemEn",    32'(MemEn),   32'd0);
        check("flush_GPRWE_",   32'(MemGPRWE_), 32'd1);
        $display("txn flush done MemEn=%0d", MemEn);
        Flush = 1'b0; ExEn = 1'b0;
        @(negedge clk);

        // Reset in the middle of an ACCESS
        run_instr(1, 2'd0, 32'h0000_0022, 32'h0, 5'd1, 0, 3'd0, 0, 0, 0, 32'h0);
        ExEn = 1'b1; ExMemOp = 2'd1; ExOut = 32'h0000_0300; ExExpCode = '0;
        begin
            int  k;
            logic seen;
            k = 0; seen = 0;
            while (!seen && k < 10) begin
                #1;
                BusRdy_ = 1'b1;
                BusGrnt_ = BusReq_;
                if (!BusAs_) seen = 1;
                else begin
                    k++;
                    @(negedge clk);
                end
            end
            check("rst_reach_access", 32'(seen), 32'd1);
        end
        reset_ = 1'b0;
        #1;
        check_idle_outputs("midrst");
        $display("txn reset during access");
        @(negedge clk);
        ExEn = 1'b0; BusGrnt_ = 1'b1;
        @(negedge clk);
        reset_ = 1'b1;
        @(negedge clk);
        run_instr(1, 2'd1, 32'h0000_0040, 32'h0, 5'd5, 0, 3'd0, 1, 0, 0, 32'h1357_9BDF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
